bus_ack_controller: RTL



---
 rtl/bus_ack_pkg.sv | 31 +++
 rtl/bus_ack_controller_if.sv | 28 ++
 rtl/bus_timeout_timer.sv | 37 +++
 rtl/bus_ack_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bus_ack_pkg.sv
// Shared types and helpers for the 68030 bus acknowledge controller.
// Port-size modes and the state encoding live here so the bench can decode them too.
package bus_ack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EXT,
        ACK,
        AVEC,
        BERR
    } bus_state_e;

    localparam logic [1:0] MODE_EXT = 2'b00;
    localparam logic [1:0] MODE_8   = 2'b01;
    localparam logic [1:0] MODE_16  = 2'b10;
    localparam logic [1:0] MODE_32  = 2'b11;

    // Returns {DSACK1_n, DSACK0_n} for an internally acknowledged port size.
    function automatic logic [1:0] mode_to_dsack(input logic [1:0] mode);
        logic [1:0] pair;
        case (mode)
            MODE_8:  pair = 2'b10;
            MODE_16: pair = 2'b01;
            MODE_32: pair = 2'b00;
            default: pair = 2'b11;
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/bus_ack_controller_if.sv
// CPU-side bus signals of the acknowledge controller, grouped with master/slave views.
interface bus_ack_controller_if #(
    parameter int NUM_CH = 4
);
    // AS_n low opens a cycle; at most one of DSACK/AVEC_n/BERR_n is driven low and it
    // is held until AS_n is seen high again, which closes the cycle.
    logic              AS_n;
    logic [NUM_CH-1:0] CS_n;
    logic [NUM_CH-1:0] EXT_DSACK0_n;
    logic [NUM_CH-1:0] EXT_DSACK1_n;
    logic              AVEC_REQ;
    logic              DSACK0_n;
    logic              DSACK1_n;
    logic              AVEC_n;
    logic              BERR_n;
    logic              TIMEOUT_EVT;

    modport master (
        output AS_n, CS_n, EXT_DSACK0_n, EXT_DSACK1_n, AVEC_REQ,
        input  DSACK0_n, DSACK1_n, AVEC_n, BERR_n, TIMEOUT_EVT
    );

    modport slave (
        input  AS_n, CS_n, EXT_DSACK0_n, EXT_DSACK1_n, AVEC_REQ,
        output DSACK0_n, DSACK1_n, AVEC_n, BERR_n, TIMEOUT_EVT
    );

endinterface

// File: rtl/bus_timeout_timer.sv
// Saturating bus watchdog; expire flags the edge on which the count reaches TIMEOUT.
module bus_timeout_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = &{1'b0, CLK, RST_n, clr, en};
            assign expire        = 1'b0;
        end else begin : g_enabled
            logic [CNT_W-1:0] count;

            always_ff @(posedge CLK or negedge RST_n) begin
                if (!RST_n) begin
                    count <= '0;
                end else if (clr) begin
                    count <= '0;
                end else if (en && count != CNT_W'(TIMEOUT)) begin
                    count <= count + CNT_W'(1);
                end
            end

            // Combinational so the owner can register BERR on the same edge the count lands.
            assign expire = en && (count == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/bus_ack_controller.sv
// Clocked DSACK/AVEC/BERR generator for the 68030: per-channel wait states and port size,
// external acknowledge pass-through, autovector acknowledge and a bus-timeout watchdog.
module bus_ack_controller
    import bus_ack_pkg::*;
#(
    parameter int                         NUM_CH  = 4,
    parameter int                         WAIT_W  = 4,
    parameter logic [NUM_CH*WAIT_W-1:0]   CH_WAIT = 16'h0200,
    parameter logic [NUM_CH*2-1:0]        CH_MODE = 8'b00_10_01_01,
    parameter int                         TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                RST_n,
    bus_ack_controller_if.slave bus,
    output bus_state_e          dbg_state
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    bus_state_e        state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic [CH_W-1:0]   ch_q, ch_nxt;
    logic [1:0]        dsack_q, dsack_nxt;
    logic              avec_q, avec_nxt;
    logic              berr_q, berr_nxt;
    logic              evt_q, evt_nxt;

    logic [CH_W-1:0]   sel;
    logic              cs_hit;
    logic [1:0]        mode_sel, mode_q;
    logic [WAIT_W-1:0] wait_sel;
    logic              wd_en, wd_expire;

    // Lowest-index active chip-select wins.
    always_comb begin
        sel    = '0;
        cs_hit = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!bus.CS_n[i]) begin
                sel    = CH_W'(i);
                cs_hit = 1'b1;
            end
        end
    end

    assign mode_sel = CH_MODE[2*int'(sel) +: 2];
    assign wait_sel = CH_WAIT[WAIT_W*int'(sel) +: WAIT_W];
    assign mode_q   = CH_MODE[2*int'(ch_q) +: 2];

    assign wd_en = !bus.AS_n && (state == IDLE || state == WAIT || state == EXT);

    bus_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .clr    (!wd_en),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ch_q    <= '0;
            dsack_q <= 2'b11;
            avec_q  <= 1'b1;
            berr_q  <= 1'b1;
            evt_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ch_q    <= ch_nxt;
            dsack_q <= dsack_nxt;
            avec_q  <= avec_nxt;
            berr_q  <= berr_nxt;
            evt_q   <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch_q;
        dsack_nxt = dsack_q;
        avec_nxt  = avec_q;
        berr_nxt  = berr_q;
        evt_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.AS_n) begin
                    if (bus.AVEC_REQ) begin
                        state_nxt = AVEC;
                        avec_nxt  = 1'b0;
                    end else if (cs_hit && mode_sel != MODE_EXT && wait_sel == '0) begin
                        ch_nxt    = sel;
                        state_nxt = ACK;
                        dsack_nxt = mode_to_dsack(mode_sel);
                    end else if (wd_expire) begin
                        state_nxt = BERR;
                        berr_nxt  = 1'b0;
                        evt_nxt   = 1'b1;
                    end else if (cs_hit) begin
                        ch_nxt = sel;
                        if (mode_sel == MODE_EXT) begin
                            state_nxt = EXT;
                        end else begin
                            cnt_nxt   = wait_sel;
                            state_nxt = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (bus.AS_n) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == WAIT_W'(1)) begin
                    state_nxt = ACK;
                    cnt_nxt   = '0;
                    dsack_nxt = mode_to_dsack(mode_q);
                end else if (wd_expire) begin
                    state_nxt = BERR;
                    cnt_nxt   = '0;
                    berr_nxt  = 1'b0;
                    evt_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end
            end
            EXT: begin
                if (bus.AS_n) begin
                    state_nxt = IDLE;
                end else if (!bus.EXT_DSACK0_n[ch_q] || !bus.EXT_DSACK1_n[ch_q]) begin
                    state_nxt = ACK;
                    dsack_nxt = {bus.EXT_DSACK1_n[ch_q], bus.EXT_DSACK0_n[ch_q]};
                end else if (wd_expire) begin
                    state_nxt = BERR;
                    berr_nxt  = 1'b0;
                    evt_nxt   = 1'b1;
                end
            end
            ACK, AVEC, BERR: begin
                if (bus.AS_n) begin
                    state_nxt = IDLE;
                    dsack_nxt = 2'b11;
                    avec_nxt  = 1'b1;
                    berr_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                dsack_nxt = 2'b11;
                avec_nxt  = 1'b1;
                berr_nxt  = 1'b1;
            end
        endcase
    end

    assign bus.DSACK1_n    = dsack_q[1];
    assign bus.DSACK0_n    = dsack_q[0];
    assign bus.AVEC_n      = avec_q;
    assign bus.BERR_n      = berr_q;
    assign bus.TIMEOUT_EVT = evt_q;
    assign dbg_state       = state;

endmodule
